// File: rtl/sdram_burst_fifo_if.sv
// Handshake bundle between the SDRAM burst engine (producer), the FWFT FIFO and its consumer.
// The master drives push/pop/flush requests; the slave (the FIFO) returns head data and status.
interface sdram_burst_fifo_if #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
);
   logic             flush;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             full;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [DEPTH:0]   level;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  full, rd_data, rd_valid, level, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output full, rd_data, rd_valid, level, overflow, underflow
   );
endinterface

// File: rtl/sdram_burst_fifo.sv
// First-word-fall-through FIFO built on a registered-read dual-port RAM.
// The RAM read register doubles as a one-word skid, so full-rate pops never bubble.
module sdram_burst_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   sdram_burst_fifo_if.slave     bus
);

   localparam int unsigned  CAP   = 2 ** DEPTH;
   localparam logic [DEPTH:0] CAP_L = {1'b1, {DEPTH{1'b0}}};

   typedef enum logic [1:0] {EMPTY, FETCH, VALID} state_t;

   logic [WIDTH-1:0] mem [CAP];
   logic [WIDTH-1:0] pf_data_p1_q;

   state_t           state_q,   state_d;
   logic             vld_p1_q,  vld_p1_d;
   logic [DEPTH-1:0] wptr_q,    wptr_d;
   logic [DEPTH-1:0] rptr_q,    rptr_d;
   logic [DEPTH:0]   level_q,   level_d;
   logic             full_q,    full_d;
   logic             ovf_q,     ovf_d;
   logic             udf_q,     udf_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   logic             rd_vld;
   logic             push, pop, move, issue, mem_we;
   logic [DEPTH:0]   ram_cnt;

   assign rd_vld = (state_q == VALID);

   always_comb begin
      push    = bus.wr_en & ~full_q;
      pop     = bus.rd_en & rd_vld;
      move    = vld_p1_q & (~rd_vld | pop);
      // Words still sitting in the RAM, i.e. not yet in the skid or output register.
      ram_cnt = level_q - (DEPTH+1)'(vld_p1_q) - (DEPTH+1)'(rd_vld);
      issue   = (ram_cnt != '0) & (~vld_p1_q | move);
      mem_we  = push & ~bus.flush;

      state_d   = state_q;
      vld_p1_d  = issue | (vld_p1_q & ~move);
      wptr_d    = wptr_q + DEPTH'(push);
      rptr_d    = rptr_q + DEPTH'(issue);
      level_d   = level_q + (DEPTH+1)'(push) - (DEPTH+1)'(pop);
      full_d    = (level_d == CAP_L);
      ovf_d     = ovf_q | (bus.wr_en & full_q);
      udf_d     = udf_q | (bus.rd_en & ~rd_vld);
      rd_data_d = move ? pf_data_p1_q : rd_data_q;

      if (move)
         state_d = VALID;
      else if (pop)
         state_d = issue ? FETCH : EMPTY;
      else if (issue && state_q == EMPTY)
         state_d = FETCH;

      if (bus.flush) begin
         state_d   = EMPTY;
         vld_p1_d  = 1'b0;
         wptr_d    = '0;
         rptr_d    = '0;
         level_d   = '0;
         full_d    = 1'b0;
         ovf_d     = 1'b0;
         udf_d     = 1'b0;
         rd_data_d = rd_data_q;
      end
   end

   // Stage p0 -> p1: RAM write port and registered RAM read into the skid.
   always_ff @(posedge clock) begin
      if (mem_we)
         mem[wptr_q] <= bus.wr_data;
      if (issue)
         pf_data_p1_q <= mem[rptr_q];
   end

   // Stage p1 -> p2: control state and output register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= EMPTY;
         vld_p1_q  <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         vld_p1_q  <= vld_p1_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign bus.full      = full_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_vld;
   assign bus.level     = level_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;

endmodule

// File: tb/tb_sdram_burst_fifo.sv
// Bench for sdram_burst_fifo: directed vector table, hand sequences for the corner cases,
// and random traffic against a queue model where a word is visible two edges after its push.
module tb_sdram_burst_fifo;

   localparam int DEPTH = 8;
   localparam int WIDTH = 32;
   localparam int CAP   = 2 ** DEPTH;

   logic clock;
   logic reset_n;

   sdram_burst_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   sdram_burst_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      int          stamp;
   } entry_t;

   typedef struct {
      bit          fl;
      bit          wr;
      logic [31:0] d;
      bit          rd;
      bit          v;
      logic [31:0] rdd;
      bit          cd;
      int          lvl;
      bit          ovf;
      bit          udf;
   } vec_t;

   entry_t mq[$];
   bit     m_ovf, m_udf;
   int     cyc;
   int     n_tests, n_fail;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit model_valid(input int c);
      return (mq.size() > 0) && (mq[0].stamp <= c - 2);
   endfunction

   task automatic step(input bit fl, input bit wr, input logic [31:0] d, input bit rd);
      bit vpre, fpre, vexp;
      bus.flush   = fl;
      bus.wr_en   = wr;
      bus.wr_data = d;
      bus.rd_en   = rd;
      vpre = model_valid(cyc);
      fpre = (mq.size() == CAP);
      @(posedge clock);
      cyc++;
      if (fl) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (rd) begin
            if (vpre) void'(mq.pop_front());
            else      m_udf = 1'b1;
         end
         if (wr) begin
            if (fpre) m_ovf = 1'b1;
            else      mq.push_back('{d, cyc});
         end
      end
      #1;
      vexp = model_valid(cyc);
      check("model_level",     64'(bus.level),     64'(mq.size()));
      check("model_full",      64'(bus.full),      64'(mq.size() == CAP));
      check("model_overflow",  64'(bus.overflow),  64'(m_ovf));
      check("model_underflow", 64'(bus.underflow), 64'(m_udf));
      check("model_rd_valid",  64'(bus.rd_valid),  64'(vexp));
      if (vexp)
         check("model_rd_data", 64'(bus.rd_data), 64'(mq[0].data));
   endtask

   task automatic apply_reset();
      bus.flush   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      reset_n     = 1'b0;
      #1;
      check("rst_full",      64'(bus.full),      64'd0);
      check("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
      check("rst_rd_data",   64'(bus.rd_data),   64'd0);
      check("rst_level",     64'(bus.level),     64'd0);
      check("rst_overflow",  64'(bus.overflow),  64'd0);
      check("rst_underflow", 64'(bus.underflow), 64'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   vec_t tbl [14];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      reset_n = 1'b1;
      #2;

      //            fl wr data          rd v  rd_data       cd lvl ovf udf
      tbl[0]  = '{0, 1, 32'h11111111, 0, 0, 32'h0,        0, 1, 0, 0};
      tbl[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0};
      tbl[2]  = '{0, 0, 32'h0,        0, 1, 32'h11111111, 1, 1, 0, 0};
      tbl[3]  = '{0, 0, 32'h0,        0, 1, 32'h11111111, 1, 1, 0, 0};
      tbl[4]  = '{0, 0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0};
      tbl[5]  = '{0, 0, 32'h0,        1, 0, 32'h11111111, 1, 0, 0, 1};
      tbl[6]  = '{0, 1, 32'h22222222, 0, 0, 32'h0,        0, 1, 0, 1};
      tbl[7]  = '{0, 1, 32'h33333333, 0, 0, 32'h0,        0, 2, 0, 1};
      tbl[8]  = '{0, 0, 32'h0,        0, 1, 32'h22222222, 1, 2, 0, 1};
      tbl[9]  = '{0, 0, 32'h0,        1, 1, 32'h33333333, 1, 1, 0, 1};
      tbl[10] = '{0, 1, 32'h44444444, 1, 0, 32'h0,        0, 1, 0, 1};
      tbl[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1};
      tbl[12] = '{0, 0, 32'h0,        0, 1, 32'h44444444, 1, 1, 0, 1};
      tbl[13] = '{1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0};

      apply_reset();

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].fl, tbl[i].wr, tbl[i].d, tbl[i].rd);
         check($sformatf("vec%0d_rd_valid", i),  64'(bus.rd_valid),  64'(tbl[i].v));
         check($sformatf("vec%0d_level", i),     64'(bus.level),     64'(tbl[i].lvl));
         check($sformatf("vec%0d_overflow", i),  64'(bus.overflow),  64'(tbl[i].ovf));
         check($sformatf("vec%0d_underflow", i), 64'(bus.underflow), 64'(tbl[i].udf));
         if (tbl[i].cd)
            check($sformatf("vec%0d_rd_data", i), 64'(bus.rd_data), 64'(tbl[i].rdd));
      end

      // Fill to capacity, overflow once, then drain at full rate.
      step(1, 0, 0, 0);
      for (int i = 0; i < CAP; i++) step(0, 1, 32'(i), 0);
      check("fill_full",  64'(bus.full),  64'd1);
      check("fill_level", 64'(bus.level), 64'(CAP));
      step(0, 1, 32'hDEADBEEF, 0);
      check("ovf_flag",  64'(bus.overflow), 64'd1);
      check("ovf_level", 64'(bus.level),    64'(CAP));
      for (int i = 0; i < CAP; i++) begin
         check("drain_valid", 64'(bus.rd_valid), 64'd1);
         check("drain_data",  64'(bus.rd_data),  64'(i));
         step(0, 0, 0, 1);
      end
      check("drain_empty_valid", 64'(bus.rd_valid), 64'd0);
      check("drain_empty_level", 64'(bus.level),    64'd0);

      // Wrap-around: steady push+pop at level 3 for 600 cycles.
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 32'(1000 + i), 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         check("wrap_level", 64'(bus.level),    64'd3);
         check("wrap_valid", 64'(bus.rd_valid), 64'd1);
         check("wrap_data",  64'(bus.rd_data),  64'(1000 + i));
         step(0, 1, 32'(1003 + i), 1);
      end

      // Flush at level 5 with a simultaneous push and pop.
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      check("udf_empty_set",   64'(bus.underflow), 64'd1);
      check("udf_empty_level", 64'(bus.level),     64'd0);
      for (int i = 0; i < 5; i++) step(0, 1, 32'(50 + i), 0);
      step(0, 0, 0, 0);
      check("pre_flush_level", 64'(bus.level), 64'd5);
      step(1, 1, 32'h77777777, 1);
      check("flush_level",     64'(bus.level),     64'd0);
      check("flush_valid",     64'(bus.rd_valid),  64'd0);
      check("flush_underflow", 64'(bus.underflow), 64'd0);
      check("flush_overflow",  64'(bus.overflow),  64'd0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         check("post_flush_valid", 64'(bus.rd_valid), 64'd0);
         check("post_flush_level", 64'(bus.level),    64'd0);
      end

      // Reset mid-burst at level 7.
      for (int i = 0; i < 7; i++) step(0, 1, 32'(70 + i), 0);
      check("pre_reset_level", 64'(bus.level), 64'd7);
      apply_reset();
      step(0, 1, 32'hA5A5A5A5, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("post_reset_valid", 64'(bus.rd_valid), 64'd1);
      check("post_reset_data",  64'(bus.rd_data),  64'hA5A5A5A5);
      step(0, 0, 0, 1);
      check("post_reset_level", 64'(bus.level), 64'd0);

      // Random traffic in phases that hit full, empty and occasional flush.
      for (int ph = 0; ph < 4; ph++) begin
         int wp, rp, fp;
         case (ph)
            0:       begin wp = 90; rp = 30; fp = 0; end
            1:       begin wp = 30; rp = 90; fp = 0; end
            2:       begin wp = 70; rp = 70; fp = 2; end
            default: begin wp = 95; rp = 95; fp = 0; end
         endcase
         for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 999) < fp),
                 ($urandom_range(0, 99) < wp),
                 $urandom,
                 ($urandom_range(0, 99) < rp));
         end
      end

      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.flush = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_burst_fifo.md
# sdram_burst_fifo

Synchronous first-word-fall-through FIFO controller for the SDRAM data path. An SDRAM burst engine pushes words into it, and a cache or chipset consumer pops them. Storage is an internal inferred dual-port RAM with a registered read (one-cycle read latency), so the block adds the pointer logic, the prefetch pipeline and the output register that turn a registered-read RAM into a zero-latency FWFT interface. It also keeps occupancy and error flags.

## Interface
Parameters:
- depth, 8, address bits; capacity is 2**depth words
- width, 32, data word width

Ports:
- clock  in  1  single system clock, all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all contents and flags
- wr_en  in  1  push request
- wr_data  in  width  push data
- full  out  1  high when level == 2**depth
- rd_en  in  1  pop request; acknowledges the current rd_data
- rd_data  out  width  head word; valid only while rd_valid is high
- rd_valid  out  1  head word present (FWFT, i.e. not empty)
- level  out  depth+1  words stored, including the word in the output register
- overflow  out  1  sticky; a push was attempted while full
- underflow  out  1  sticky; a pop was attempted while rd_valid was low

## Operation
- Storage:
  - RAM with 2**depth entries.
  - Write pointer and read pointer are depth bits wide and wrap modulo 2**depth.
  - The RAM write port is driven by the write pointer. The RAM read port is driven by the prefetch pointer.
- Push: accepted when wr_en is high and full is low. The word is written at the write pointer, and the pointer increments.
- Push while full: the word is dropped, overflow is set, and the pointers are unchanged. full is judged on the registered value, so a push is rejected even when a pop happens in the same cycle.
- Pop: accepted when rd_en is high and rd_valid is high. The head is consumed, and the next word appears on rd_data as soon as the prefetch pipeline has it.
- Pop while rd_valid is low: ignored, and underflow is set.
- Prefetch pipeline, states EMPTY, FETCH, VALID:
  - EMPTY -> FETCH: the RAM holds at least one unread word. The RAM read is issued.
  - FETCH -> VALID: the registered RAM data is loaded into rd_data.
  - VALID -> FETCH: a pop is accepted and further RAM words remain.
  - VALID -> EMPTY: a pop is accepted and no RAM words remain.
  - VALID holds otherwise.
  - A read is never issued to an address written on the same edge; only words written on an earlier edge are fetched. A same-address read-during-write therefore never occurs.
- Back-to-back pops: the controller reads ahead, so consecutive pops at full rate return consecutive words with rd_valid continuously high. This requires a one-word skid or a direct RAM read on the pop cycle; the implementation chooses the mechanism, but there must be no bubble once two or more words are stored.
- level:
  - +1 on an accepted push only, -1 on an accepted pop only.
  - Unchanged on push+pop in the same cycle.
  - Never exceeds 2**depth and never goes below 0.
- flush:
  - Has priority over wr_en and rd_en in the same cycle.
  - Clears the pointers, level, rd_valid, overflow and underflow.
  - Returns the pipeline to EMPTY.
  - RAM contents are left as they are.

## Timing
- Reset values (asynchronous, while reset_n is low): full=0, rd_valid=0, rd_data=0, level=0, overflow=0, underflow=0. Pipeline state is EMPTY.
- Reset mid-burst: all state is discarded immediately. There are no accepted pushes or pops on the edge where reset_n rises.
- Push-to-valid latency into an empty FIFO: a push sampled at edge E0 gives rd_valid=1 with that word after edge E2.
- level and full update one edge after the accepted push or pop.
- overflow and underflow assert one edge after the offending request and hold until flush or reset.
- Sustained throughput: one push and one pop per cycle simultaneously, with level constant.
- rd_data holds its value while rd_valid is high and rd_en is low.

## Test plan
- Reset then push 0x11111111 at E0: rd_valid=0 after E1, rd_valid=1 and rd_data=0x11111111 after E2, level=1.
- Push 256 words 0..255 (depth=8): full=1, level=256. A 257th push sets overflow=1 and level stays 256. Pop all 256: data comes out 0..255 in order with no rd_valid gaps, then rd_valid=0.
- Wrap-around: run 600 pushes with concurrent pops at full rate, starting from level=3. The popped sequence is strictly ordered and level stays 3 throughout.
- Pop on empty: rd_en=1 with rd_valid=0 sets underflow=1; level stays 0 and rd_data does not change.
- Flush while level=5 with wr_en=1 and rd_en=1 in the same cycle: next cycle level=0, rd_valid=0, flags cleared, and the flush-cycle push is discarded.
- Assert reset_n=0 mid-burst at level=7: all outputs read zero immediately. After release, a fresh push of 0xA5A5A5A5 is the first word popped.
